// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths and read-owner encoding for the data-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned STARVE_W   = 8;

   typedef enum logic [1:0] {
      RD_NONE = 2'b00,
      RD_CPU  = 2'b01,
      RD_EXT  = 2'b10
   } rd_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Core, external-requester and block-RAM signals of the arbiter.
interface data_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic              ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_addr, mem_we, mem_din,
      input  mem_dout
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_addr, mem_we, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles the external requester has been denied.
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic force_gnt
);
   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign force_gnt = (cnt >= STARVE_W'(LIMIT));
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data block RAM between the core (priority) and an
// external requester, with a forced external slot on starvation.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic               CLK,
   input logic               reset,
   data_mem_arbiter_if.slave bus
);
   logic              force_gnt;
   logic              grant_ext;
   logic              grant_cpu;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] din_sel;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] ext_hold;
   rd_state_t         rd_state;
   rd_state_t         rd_next;

   assign grant_ext = bus.ext_req & (~bus.cpu_req | force_gnt);
   assign grant_cpu = bus.cpu_req & ~grant_ext;

   assign bus.ext_gnt   = grant_ext;
   assign bus.cpu_stall = bus.cpu_req & grant_ext;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (CLK),
      .rst       (reset),
      .clr       (grant_ext | ~bus.ext_req),
      .inc       (bus.ext_req & bus.cpu_req & ~grant_ext),
      .force_gnt (force_gnt)
   );

   assign addr_sel     = grant_ext ? bus.ext_addr  : bus.cpu_addr;
   assign din_sel      = grant_ext ? bus.ext_wdata : bus.cpu_wdata;
   assign bus.mem_addr = addr_sel;
   assign bus.mem_din  = din_sel;
   assign bus.mem_we   = ~reset &
                         ((grant_ext & bus.ext_we) |
                          (grant_cpu & bus.cpu_we));

   // Records who owns the data coming back on mem_dout next cycle.
   always_comb begin
      rd_next = RD_NONE;
      unique case (1'b1)
         grant_cpu & ~bus.cpu_we: rd_next = RD_CPU;
         grant_ext & ~bus.ext_we: rd_next = RD_EXT;
         default:                 rd_next = RD_NONE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         rd_state <= RD_NONE;
         cpu_hold <= '0;
         ext_hold <= '0;
      end else begin
         rd_state <= rd_next;
         if (rd_state == RD_CPU) cpu_hold <= bus.mem_dout;
         if (rd_state == RD_EXT) ext_hold <= bus.mem_dout;
      end
   end

   // A read in flight when reset arrives is dropped, not returned.
   always_comb begin
      bus.cpu_rvalid = 1'b0;
      bus.ext_rvalid = 1'b0;
      bus.cpu_rdata  = cpu_hold;
      bus.ext_rdata  = ext_hold;
      if (reset) begin
         bus.cpu_rdata = '0;
         bus.ext_rdata = '0;
      end else begin
         unique case (rd_state)
            RD_CPU: begin
               bus.cpu_rvalid = 1'b1;
               bus.cpu_rdata  = bus.mem_dout;
            end
            RD_EXT: begin
               bus.ext_rvalid = 1'b1;
               bus.ext_rdata  = bus.mem_dout;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 4K x 16 data block memory between the stack core (load/store path) and an external requester (loader/debug/display reader).
- The core has priority. A starvation counter forces an external slot after STARVE_LIMIT consecutive denied cycles; the core is then stalled for one cycle.
- Sits between the core's data-memory port and the block memory instance. It replaces the direct wiring of address, write enable and write data.

Parameters:
- ADDR_W, 12, word-address width (memory depth 2^ADDR_W).
- DATA_W, 16, data width.
- STARVE_LIMIT, 8, consecutive denied external-request cycles before a forced external grant (legal range 1..255).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  core access request this cycle.
- cpu_we  in  1  core write (1) / read (0).
- cpu_addr  in  ADDR_W  core word address.
- cpu_wdata  in  DATA_W  core write data.
- cpu_stall  out  1  core access not taken this cycle; core must hold PC and retry.
- cpu_rvalid  out  1  core read data valid.
- cpu_rdata  out  DATA_W  core read data. Holds the last read value.
- ext_req  in  1  external request; held stable with its fields until ext_gnt.
- ext_we  in  1  external write/read.
- ext_addr  in  ADDR_W  external word address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access taken this cycle.
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  DATA_W  external read data. Holds the last read value.
- mem_addr  out  ADDR_W  to block memory addra.
- mem_we  out  1  to block memory wea.
- mem_din  out  DATA_W  to block memory dina.
- mem_dout  in  DATA_W  from block memory douta; valid 1 cycle after the address edge.

Behaviour:
- Grant (combinational, same cycle):
  - force = (starve_cnt >= STARVE_LIMIT).
  - grant_ext = ext_req & (~cpu_req | force).
  - grant_cpu = cpu_req & ~grant_ext.
- Outputs derived from the grant:
  - ext_gnt = grant_ext.
  - cpu_stall = cpu_req & grant_ext.
- Memory port mux:
  - grant_ext: ext fields drive mem_addr and mem_din.
  - otherwise: cpu fields drive mem_addr and mem_din.
  - mem_we = (grant_ext & ext_we) | (grant_cpu & cpu_we); forced 0 while reset=1.
- starve_cnt (8-bit, registered):
  - Clears to 0 on reset, on grant_ext, or when ext_req=0.
  - Increments when ext_req & cpu_req & ~grant_ext; saturates at 255.
- Read-owner FSM (registered), states:
  - RD_NONE: no read issued last cycle.
  - RD_CPU: core read issued last cycle.
  - RD_EXT: external read issued last cycle.
  - Next state: RD_CPU on a granted core read, RD_EXT on a granted external read, RD_NONE otherwise (including writes and idle).
- Read data return:
  - RD_CPU: cpu_rvalid=1 and cpu_rdata=mem_dout for that cycle; mem_dout is also captured into the cpu hold register.
  - RD_EXT: same, for the ext outputs.
  - Outside a valid cycle, rdata outputs show their hold register.
  - Read latency is exactly 1 cycle from grant. Back-to-back reads sustain 1 per cycle.
- Writes: committed at the grant edge; no response strobe.
- Read-after-write to the same address on consecutive cycles returns the new data (memory write-first mode).
- Simultaneous requests:
  - force=0: core wins, ext waits with ext_gnt=0.
  - force=1: ext wins, cpu_stall=1 for exactly that cycle; the counter clears, so the core wins the next cycle.
- Reset (including mid-read):
  - FSM to RD_NONE; pending read discarded, so no rvalid the cycle after reset.
  - starve_cnt=0; hold registers=0.
  - Output values during reset: cpu_rvalid=0, ext_rvalid=0, cpu_rdata=0, ext_rdata=0, mem_we=0.
  - cpu_stall and ext_gnt still follow the grant equations; no memory write occurs.
- Idle (no requests): mem_addr = cpu_addr, mem_we=0, FSM to RD_NONE.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Read-owner state encoding: RD_NONE=2'b00, RD_CPU=2'b01, RD_EXT=2'b10.
  - Starvation counter width (8).
- One sub-module, arb_starve_counter: saturating 8-bit counter with clear, increment and a `force` compare output against STARVE_LIMIT.
- Grant logic, mux, FSM and hold registers stay in the top.

Test Plan:
- Reset then core write addr 0x010 = 0xBEEF, core read 0x010 next cycle: cpu_rvalid=1 one cycle later with cpu_rdata=0xBEEF; cpu_rdata holds 0xBEEF afterwards; cpu_stall never 1.
- ext_req alone, read of 0x020 preloaded 0x1234: ext_gnt=1 same cycle; ext_rvalid=1 and ext_rdata=0x1234 next cycle; cpu outputs untouched.
- cpu_req and ext_req held continuously, STARVE_LIMIT=8:
  - ext_gnt=0 for 8 cycles, then ext_gnt=1 and cpu_stall=1 in cycle 9 only.
  - Pattern repeats every 9 cycles.
  - starve_cnt returns to 0 after each grant.
- Interleaved reads, core 0x001 (=0x00AA) and ext 0x002 (=0x00BB) on adjacent cycles: each rvalid goes only to its owner; data is not crossed.
- Reset asserted the cycle after a granted core read: no cpu_rvalid next cycle; cpu_rdata=0; mem_we=0 during reset even with cpu_req=1, cpu_we=1.
- ext_req dropped after 5 denied cycles, then re-asserted: forced grant occurs only after a further 8 denied cycles (counter cleared).
